// File: rtl/jump_branch_redirect_ctrl.sv
// PC redirect sequencer: arbitrates EX branch vs ID jump, forms the target,
// then issues a one-cycle PC-load strobe followed by a multi-cycle IF/ID flush.
module jump_branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int COUNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               StallIn,
  input  logic               IdJumpReq,
  input  logic               IdJumpReg,
  input  logic [25:0]        IdInstrIndex,
  input  logic [31:0]        IdPcPlus4,
  input  logic [31:0]        IdRegTarget,
  input  logic               ExBranchReq,
  input  logic [31:0]        ExBranchTarget,
  output logic               PCSrcValid,
  output logic [31:0]        PCTarget,
  output logic               FlushIF,
  output logic               FlushID,
  output logic               TargetMisaligned,
  output logic               JumpDropped,
  output logic               Busy,
  output logic [COUNT_W-1:0] RedirectCount
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e               state_q, state_d;
  logic [2:0]           flush_cnt_q, flush_cnt_d;
  logic                 pc_src_valid_q, pc_src_valid_d;
  logic [31:0]          pc_target_q, pc_target_d;
  logic                 flush_if_q, flush_if_d;
  logic                 flush_id_q, flush_id_d;
  logic                 misaligned_q, misaligned_d;
  logic                 jump_dropped_q, jump_dropped_d;
  logic                 busy_q, busy_d;
  logic [COUNT_W-1:0]   redirect_count_q, redirect_count_d;
  logic [31:0]          accept_target;
  logic                 unused_pc_bits;

  // Only the region bits of PC+4 feed a J target.
  assign unused_pc_bits = ^IdPcPlus4[27:0];

  always_comb begin
    if (ExBranchReq)    accept_target = ExBranchTarget;
    else if (IdJumpReg) accept_target = IdRegTarget;
    else                accept_target = {IdPcPlus4[31:28], IdInstrIndex, 2'b00};
  end

  // A stall freezes every register; in IDLE that also blocks acceptance.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    pc_src_valid_d   = pc_src_valid_q;
    pc_target_d      = pc_target_q;
    flush_if_d       = flush_if_q;
    flush_id_d       = flush_id_q;
    misaligned_d     = misaligned_q;
    jump_dropped_d   = jump_dropped_q;
    busy_d           = busy_q;
    redirect_count_d = redirect_count_q;
    if (!StallIn) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ExBranchReq || IdJumpReq) begin
            state_d          = ST_REDIRECT;
            pc_src_valid_d   = 1'b1;
            pc_target_d      = accept_target;
            misaligned_d     = (accept_target[1:0] != 2'b00);
            jump_dropped_d   = ExBranchReq && IdJumpReq;
            flush_if_d       = 1'b1;
            flush_id_d       = ExBranchReq;
            busy_d           = 1'b1;
            redirect_count_d = redirect_count_q + COUNT_W'(1);
          end
        end
        ST_REDIRECT: begin
          pc_src_valid_d = 1'b0;
          misaligned_d   = 1'b0;
          jump_dropped_d = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end else begin
            state_d    = ST_IDLE;
            flush_if_d = 1'b0;
            flush_id_d = 1'b0;
            busy_d     = 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q <= 3'd1) begin
            state_d     = ST_IDLE;
            flush_cnt_d = 3'd0;
            flush_if_d  = 1'b0;
            flush_id_d  = 1'b0;
            busy_d      = 1'b0;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          flush_cnt_d = 3'd0;
          flush_if_d  = 1'b0;
          flush_id_d  = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= 3'd0;
      pc_src_valid_q   <= 1'b0;
      pc_target_q      <= 32'd0;
      flush_if_q       <= 1'b0;
      flush_id_q       <= 1'b0;
      misaligned_q     <= 1'b0;
      jump_dropped_q   <= 1'b0;
      busy_q           <= 1'b0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      pc_src_valid_q   <= pc_src_valid_d;
      pc_target_q      <= pc_target_d;
      flush_if_q       <= flush_if_d;
      flush_id_q       <= flush_id_d;
      misaligned_q     <= misaligned_d;
      jump_dropped_q   <= jump_dropped_d;
      busy_q           <= busy_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign PCSrcValid       = pc_src_valid_q;
  assign PCTarget         = pc_target_q;
  assign FlushIF          = flush_if_q;
  assign FlushID          = flush_id_q;
  assign TargetMisaligned = misaligned_q;
  assign JumpDropped      = jump_dropped_q;
  assign Busy             = busy_q;
  assign RedirectCount    = redirect_count_q;

endmodule

// File: tb/tb_jump_branch_redirect_ctrl.sv
// Directed bench for jump_branch_redirect_ctrl: three instances (FLUSH_CYCLES 1/3/4)
// share one stimulus set; each scenario checks the instance it targets.
module tb_jump_branch_redirect_ctrl;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        id_jump_req;
  logic        id_jump_reg;
  logic [25:0] id_instr_index;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_reg_target;
  logic        ex_branch_req;
  logic [31:0] ex_branch_target;

  logic        a_valid, a_fif, a_fid, a_mis, a_drop, a_busy;
  logic [31:0] a_tgt;
  logic [15:0] a_cnt;
  logic        b_valid, b_fif, b_fid, b_mis, b_drop, b_busy;
  logic [31:0] b_tgt;
  logic [15:0] b_cnt;
  logic        c_valid, c_fif, c_fid, c_mis, c_drop, c_busy;
  logic [31:0] c_tgt;
  logic [1:0]  c_cnt;

  int n_vec;
  int n_err;

  jump_branch_redirect_ctrl #(.FLUSH_CYCLES(1), .COUNT_W(16)) u_dut_a (
    .Clk(clk), .Reset(reset), .StallIn(stall_in), .IdJumpReq(id_jump_req),
    .IdJumpReg(id_jump_reg), .IdInstrIndex(id_instr_index), .IdPcPlus4(id_pc_plus4),
    .IdRegTarget(id_reg_target), .ExBranchReq(ex_branch_req), .ExBranchTarget(ex_branch_target),
    .PCSrcValid(a_valid), .PCTarget(a_tgt), .FlushIF(a_fif), .FlushID(a_fid),
    .TargetMisaligned(a_mis), .JumpDropped(a_drop), .Busy(a_busy), .RedirectCount(a_cnt));

  jump_branch_redirect_ctrl #(.FLUSH_CYCLES(3), .COUNT_W(16)) u_dut_b (
    .Clk(clk), .Reset(reset), .StallIn(stall_in), .IdJumpReq(id_jump_req),
    .IdJumpReg(id_jump_reg), .IdInstrIndex(id_instr_index), .IdPcPlus4(id_pc_plus4),
    .IdRegTarget(id_reg_target), .ExBranchReq(ex_branch_req), .ExBranchTarget(ex_branch_target),
    .PCSrcValid(b_valid), .PCTarget(b_tgt), .FlushIF(b_fif), .FlushID(b_fid),
    .TargetMisaligned(b_mis), .JumpDropped(b_drop), .Busy(b_busy), .RedirectCount(b_cnt));

  jump_branch_redirect_ctrl #(.FLUSH_CYCLES(4), .COUNT_W(2)) u_dut_c (
    .Clk(clk), .Reset(reset), .StallIn(stall_in), .IdJumpReq(id_jump_req),
    .IdJumpReg(id_jump_reg), .IdInstrIndex(id_instr_index), .IdPcPlus4(id_pc_plus4),
    .IdRegTarget(id_reg_target), .ExBranchReq(ex_branch_req), .ExBranchTarget(ex_branch_target),
    .PCSrcValid(c_valid), .PCTarget(c_tgt), .FlushIF(c_fif), .FlushID(c_fid),
    .TargetMisaligned(c_mis), .JumpDropped(c_drop), .Busy(c_busy), .RedirectCount(c_cnt));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_in         = 1'b0;
    id_jump_req      = 1'b0;
    id_jump_reg      = 1'b0;
    id_instr_index   = 26'd0;
    id_pc_plus4      = 32'd0;
    id_reg_target    = 32'd0;
    ex_branch_req    = 1'b0;
    ex_branch_target = 32'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", a_valid); end
    n_vec++; if (a_tgt !== 32'd0) begin n_err++; $display("FAIL rst_target: got %08h want 00000000", a_tgt); end
    n_vec++; if ({a_fif, a_fid, a_mis, a_drop, a_busy} !== 5'b0) begin n_err++; $display("FAIL rst_flags: got %05b want 00000", {a_fif, a_fid, a_mis, a_drop, a_busy}); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", a_cnt); end
  endtask

  task automatic test_j();
    apply_reset();
    id_jump_req    = 1'b1;
    id_jump_reg    = 1'b0;
    id_pc_plus4    = 32'h9000_0004;
    id_instr_index = 26'h3FF_FFFF;
    tick();
    clear_inputs();
    n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL j_valid: got %0h want 1", a_valid); end
    n_vec++; if (a_tgt !== 32'h9FFF_FFFC) begin n_err++; $display("FAIL j_target: got %08h want 9ffffffc", a_tgt); end
    n_vec++; if ({a_fif, a_fid} !== 2'b10) begin n_err++; $display("FAIL j_flush: got %02b want 10", {a_fif, a_fid}); end
    n_vec++; if ({a_mis, a_drop, a_busy} !== 3'b001) begin n_err++; $display("FAIL j_misc: got %03b want 001", {a_mis, a_drop, a_busy}); end
    n_vec++; if (a_cnt !== 16'd1) begin n_err++; $display("FAIL j_count: got %0d want 1", a_cnt); end
    tick();
    n_vec++; if ({a_valid, a_fif, a_busy} !== 3'b000) begin n_err++; $display("FAIL j_done: got %03b want 000", {a_valid, a_fif, a_busy}); end
    n_vec++; if (a_tgt !== 32'h9FFF_FFFC) begin n_err++; $display("FAIL j_target_hold: got %08h want 9ffffffc", a_tgt); end
  endtask

  task automatic test_branch_vs_jump();
    apply_reset();
    ex_branch_req    = 1'b1;
    ex_branch_target = 32'h0040_0020;
    id_jump_req      = 1'b1;
    id_pc_plus4      = 32'h1234_5678;
    id_instr_index   = 26'h000_0100;
    tick();
    clear_inputs();
    n_vec++; if (a_tgt !== 32'h0040_0020) begin n_err++; $display("FAIL bvj_target: got %08h want 00400020", a_tgt); end
    n_vec++; if ({a_valid, a_fif, a_fid} !== 3'b111) begin n_err++; $display("FAIL bvj_flush: got %03b want 111", {a_valid, a_fif, a_fid}); end
    n_vec++; if (a_drop !== 1'b1) begin n_err++; $display("FAIL bvj_dropped: got %0h want 1", a_drop); end
    n_vec++; if (a_mis !== 1'b0) begin n_err++; $display("FAIL bvj_misaligned: got %0h want 0", a_mis); end
    tick();
    n_vec++; if (a_drop !== 1'b0) begin n_err++; $display("FAIL bvj_dropped_clear: got %0h want 0", a_drop); end
  endtask

  task automatic test_flush3();
    apply_reset();
    ex_branch_req    = 1'b1;
    ex_branch_target = 32'h0000_0100;
    tick();
    ex_branch_req = 1'b0;
    id_jump_req   = 1'b1;
    id_pc_plus4   = 32'h0000_0004;
    for (int i = 1; i <= 3; i++) begin
      n_vec++; if ({b_valid, b_fif, b_fid, b_busy} !== {(i == 1), 3'b111}) begin
        n_err++; $display("FAIL f3_cycle%0d: got %04b want %04b", i, {b_valid, b_fif, b_fid, b_busy}, {(i == 1), 3'b111});
      end
      tick();
    end
    // The request sampled on the last flush edge must not be taken.
    clear_inputs();
    n_vec++; if ({b_valid, b_fif, b_fid, b_busy} !== 4'b0000) begin n_err++; $display("FAIL f3_end: got %04b want 0000", {b_valid, b_fif, b_fid, b_busy}); end
    n_vec++; if (b_cnt !== 16'd1) begin n_err++; $display("FAIL f3_count: got %0d want 1", b_cnt); end
    tick();
    n_vec++; if (b_cnt !== 16'd1) begin n_err++; $display("FAIL f3_count_stable: got %0d want 1", b_cnt); end
  endtask

  task automatic test_jr();
    apply_reset();
    id_jump_req   = 1'b1;
    id_jump_reg   = 1'b1;
    id_reg_target = 32'h0000_1002;
    tick();
    clear_inputs();
    n_vec++; if (a_tgt !== 32'h0000_1002) begin n_err++; $display("FAIL jr_target: got %08h want 00001002", a_tgt); end
    n_vec++; if ({a_valid, a_mis} !== 2'b11) begin n_err++; $display("FAIL jr_misaligned: got %02b want 11", {a_valid, a_mis}); end
    n_vec++; if ({a_fif, a_fid} !== 2'b10) begin n_err++; $display("FAIL jr_flush: got %02b want 10", {a_fif, a_fid}); end
    tick();
    n_vec++; if (a_mis !== 1'b0) begin n_err++; $display("FAIL jr_mis_clear: got %0h want 0", a_mis); end
  endtask

  task automatic test_stall();
    apply_reset();
    stall_in    = 1'b1;
    id_jump_req = 1'b1;
    tick();
    n_vec++; if ({a_valid, a_busy} !== 2'b00 || a_cnt !== 16'd0) begin n_err++; $display("FAIL st_idle_block: got v%0h b%0h c%0d want v0 b0 c0", a_valid, a_busy, a_cnt); end
    stall_in       = 1'b0;
    id_pc_plus4    = 32'hA000_0000;
    id_instr_index = 26'h000_0040;
    tick();
    clear_inputs();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({a_valid, a_fif} !== 2'b11 || a_tgt !== 32'hA000_0100) begin
        n_err++; $display("FAIL st_hold%0d: got v%0h f%0h t%08h want v1 f1 ta0000100", i, a_valid, a_fif, a_tgt);
      end
      if (i < 2) tick();
    end
    stall_in = 1'b0;
    tick();
    n_vec++; if ({a_valid, a_fif, a_busy} !== 3'b000 || a_cnt !== 16'd1) begin n_err++; $display("FAIL st_done: got %03b c%0d want 000 c1", {a_valid, a_fif, a_busy}, a_cnt); end
  endtask

  task automatic test_reset_mid_flush_wrap();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      ex_branch_req    = 1'b1;
      ex_branch_target = 32'h0000_0200;
      tick();
      ex_branch_req = 1'b0;
      repeat (4) tick();
    end
    n_vec++; if (c_cnt !== 2'd0) begin n_err++; $display("FAIL wrap_count: got %0d want 0", c_cnt); end
    n_vec++; if (c_busy !== 1'b0) begin n_err++; $display("FAIL wrap_idle: got %0h want 0", c_busy); end
    ex_branch_req = 1'b1;
    tick();
    ex_branch_req = 1'b0;
    tick();
    tick();
    n_vec++; if ({c_valid, c_fif, c_fid, c_busy} !== 4'b0111 || c_cnt !== 2'd1) begin n_err++; $display("FAIL rmf_pre: got %04b c%0d want 0111 c1", {c_valid, c_fif, c_fid, c_busy}, c_cnt); end
    reset = 1'b1;
    tick();
    n_vec++; if ({c_valid, c_fif, c_fid, c_mis, c_drop, c_busy} !== 6'b0 || c_tgt !== 32'd0 || c_cnt !== 2'd0) begin
      n_err++; $display("FAIL rmf_reset: got %06b t%08h c%0d want 000000 t00000000 c0", {c_valid, c_fif, c_fid, c_mis, c_drop, c_busy}, c_tgt, c_cnt);
    end
    reset = 1'b0;
    tick();
    n_vec++; if ({c_fif, c_busy} !== 2'b00) begin n_err++; $display("FAIL rmf_after: got %02b want 00", {c_fif, c_busy}); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_j();
    test_branch_vs_jump();
    test_flush3();
    test_jr();
    test_stall();
    test_reset_mid_flush_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jump_branch_redirect_ctrl.md
Name: jump_branch_redirect_ctrl

Overview:
Sequences PC redirection for the pipelined MIPS core. Arbitrates between an EX-stage branch-taken request and an ID-stage jump request (J/JAL/JR). Forms the 32-bit jump target from the 26-bit instruction index and PC+4, then issues a registered one-cycle PC-load strobe and multi-cycle flush pulses to the IF/ID pipeline registers. Sits between the ID/EX control logic and the PC-source mux.

Parameters:
FLUSH_CYCLES, 1, cycles FlushIF/FlushID stay asserted per redirect; legal 1..7
COUNT_W, 16, width of the redirect counter

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
StallIn  input  1  pipeline stall; freezes the controller
IdJumpReq  input  1  ID stage holds a J/JAL/JR
IdJumpReg  input  1  qualifies IdJumpReq: 1 = JR (register target)
IdInstrIndex  input  26  instr[25:0] of the ID-stage jump
IdPcPlus4  input  32  PC+4 of the ID-stage instruction
IdRegTarget  input  32  forwarded rs value for JR
ExBranchReq  input  1  EX-stage branch resolved taken
ExBranchTarget  input  32  EX-stage branch target
PCSrcValid  output  1  one-cycle strobe: load PCTarget into PC
PCTarget  output  32  redirect target, valid with PCSrcValid
FlushIF  output  1  flush IF/ID register
FlushID  output  1  flush ID/EX register
TargetMisaligned  output  1  pulses with PCSrcValid when PCTarget[1:0] != 0
JumpDropped  output  1  one-cycle pulse: ID jump discarded because an EX branch won
Busy  output  1  controller is in REDIRECT or FLUSH
RedirectCount  output  COUNT_W  accepted redirects, wrapping

Behaviour:
- All outputs are registered. After Reset: state IDLE; every output is 0, including PCTarget and RedirectCount.
- States and transitions:
  - IDLE --(accept)--> REDIRECT.
  - REDIRECT lasts 1 cycle, then goes to FLUSH if FLUSH_CYCLES > 1, else to IDLE.
  - FLUSH lasts FLUSH_CYCLES-1 cycles (3-bit down-counter), then goes to IDLE.
- Accept condition: state IDLE, StallIn = 0, and (ExBranchReq | IdJumpReq).
- Requests are ignored while Busy; those instructions are on the flushed path.
- Priority:
  - ExBranchReq beats IdJumpReq, because the branch is older.
  - Branch accept: target = ExBranchTarget; flush kind = IF+ID.
  - If IdJumpReq is also high, JumpDropped = 1 in the REDIRECT cycle.
- Jump accept (IdJumpReq only):
  - Target = IdRegTarget if IdJumpReg = 1.
  - Otherwise target = {IdPcPlus4[31:28], IdInstrIndex, 2'b00}, i.e. the index zero-extended to 28 bits, shifted left 2, then concatenated.
  - Flush kind = IF only.
- Latency: request sampled at edge N. In the cycle after edge N:
  - PCSrcValid = 1 with PCTarget, TargetMisaligned and JumpDropped.
  - FlushIF = 1; FlushID = 1 for branch accepts only.
- PCSrcValid, TargetMisaligned and JumpDropped are high only in REDIRECT.
- FlushIF/FlushID hold for FLUSH_CYCLES cycles total (REDIRECT + FLUSH), then clear.
- PCTarget holds its last value after the strobe.
- Busy = 1 in REDIRECT and FLUSH.
- RedirectCount increments by 1 on each accept. It wraps from 2^COUNT_W-1 to 0 with no flag.
- StallIn = 1 outside IDLE: state, flush counter and all outputs are frozen, and PCSrcValid stays high if frozen in REDIRECT. With StallIn = 1 in IDLE, no accept occurs.
- Reset takes priority over every input, mid-redirect included. At the next edge the block is in IDLE, all outputs are 0, and any in-flight redirect is discarded.
- An IdJumpReq arriving in the same cycle the block returns to IDLE is not accepted until the next cycle.

Test Plan:
- J: IdJumpReq = 1, IdJumpReg = 0, IdPcPlus4 = 0x9000_0004, IdInstrIndex = 0x3FF_FFFF -> next cycle PCSrcValid = 1, PCTarget = 0x9FFF_FFFC, FlushIF = 1, FlushID = 0, RedirectCount = 1.
- Branch vs jump: ExBranchReq = 1 with ExBranchTarget = 0x0040_0020, IdJumpReq = 1 in the same cycle -> PCTarget = 0x0040_0020, FlushIF = FlushID = 1, JumpDropped = 1 for 1 cycle.
- FLUSH_CYCLES = 3, branch accept -> FlushIF/FlushID high exactly 3 cycles, PCSrcValid high 1 cycle, Busy high 3 cycles; a jump request during Busy is ignored and the count rises by 1 only.
- JR: IdJumpReg = 1, IdRegTarget = 0x0000_1002 -> PCTarget = 0x0000_1002, TargetMisaligned = 1 with PCSrcValid.
- StallIn = 1 asserted in the REDIRECT cycle for 2 cycles -> PCSrcValid, PCTarget and FlushIF held 3 cycles total, then normal completion.
- Reset asserted in FLUSH (FLUSH_CYCLES = 4), plus wrap: with COUNT_W = 2, after 4 accepts RedirectCount = 0 -> all outputs 0 at the next edge.
